// File: rtl/vie_sram_arbiter.sv
// Shares one single-port synchronous SRAM (1-cycle read latency) between the core's
// instruction and data request ports, and routes each response back to the port that issued it.
module vie_sram_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic       inst_valid;
    logic       data_valid;
    logic       grant_inst;
    logic       grant_data;
    logic       resp_live;
    port_e      last_grant;
    logic [3:0] starve_cnt;
    logic       resp_valid;
    port_e      resp_port;
    logic       resp_wr;

    // Misaligned halfword writes are still accepted but touch no byte lane.
    function automatic logic [3:0] lane_wen(input logic wr, input logic [1:0] size,
                                            input logic [1:0] a);
        logic [3:0] wen;
        wen = 4'b0000;
        if (wr) begin
            case (size)
                2'd0:    wen = 4'b0001 << a;
                2'd1: begin
                    case (a)
                        2'd0:    wen = 4'b0011;
                        2'd2:    wen = 4'b1100;
                        default: wen = 4'b0000;
                    endcase
                end
                default: wen = 4'b1111;
            endcase
        end
        return wen;
    endfunction

    always_comb begin
        inst_valid = inst_req & ~reset;
        data_valid = data_req & ~reset;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (inst_valid && data_valid) begin
            if (ARB_MODE == 1) begin
                grant_inst = (last_grant == PORT_DATA);
            end else begin
                grant_inst = (starve_cnt == STARVE_MAX);
            end
            grant_data = ~grant_inst;
        end else begin
            grant_inst = inst_valid;
            grant_data = data_valid;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    always_comb begin
        mem_en    = 1'b0;
        mem_wen   = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (grant_inst) begin
            mem_en    = 1'b1;
            mem_wen   = lane_wen(inst_wr, inst_size, inst_addr[1:0]);
            mem_addr  = {inst_addr[31:2], 2'b00};
            mem_wdata = inst_wdata;
        end else if (grant_data) begin
            mem_en    = 1'b1;
            mem_wen   = lane_wen(data_wr, data_size, data_addr[1:0]);
            mem_addr  = {data_addr[31:2], 2'b00};
            mem_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_port  <= PORT_INST;
            resp_wr    <= 1'b0;
            last_grant <= PORT_INST;
            starve_cnt <= 4'd0;
        end else begin
            resp_valid <= grant_inst | grant_data;
            resp_port  <= grant_data ? PORT_DATA : PORT_INST;
            resp_wr    <= grant_data ? data_wr : inst_wr;
            if (grant_inst || grant_data) begin
                last_grant <= grant_data ? PORT_DATA : PORT_INST;
            end
            if (!inst_req || grant_inst) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // A response still in flight when reset rises is dropped, not delivered.
    assign resp_live    = resp_valid & ~reset;
    assign inst_data_ok = resp_live && (resp_port == PORT_INST);
    assign data_data_ok = resp_live && (resp_port == PORT_DATA);
    assign inst_rdata   = (inst_data_ok && !resp_wr) ? mem_rdata : 32'h0;
    assign data_rdata   = (data_data_ok && !resp_wr) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_vie_sram_arbiter.sv
// Scoreboard bench for vie_sram_arbiter: a fixed-priority instance with an SRAM model and
// a round-robin instance whose fake SRAM returns the word address XOR 0xA5A50000.
module tb_vie_sram_arbiter;

    typedef struct packed {
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_on = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    req_t r_inst = '0, r_data = '0, rr_inst_r = '0, rr_data_r = '0;
    localparam req_t IDLE = '0;

    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, mem_en;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wen;
    logic        rr_inst_addr_ok, rr_inst_data_ok, rr_data_addr_ok, rr_data_data_ok, rr_mem_en;
    logic [31:0] rr_inst_rdata, rr_data_rdata, rr_mem_addr, rr_mem_wdata, rr_mem_rdata;
    logic [3:0]  rr_mem_wen;

    vie_sram_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(r_inst.req), .inst_wr(r_inst.wr), .inst_size(r_inst.size),
        .inst_addr(r_inst.addr), .inst_wdata(r_inst.wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(r_data.req), .data_wr(r_data.wr), .data_size(r_data.size),
        .data_addr(r_data.addr), .data_wdata(r_data.wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    vie_sram_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4)) dut_rr (
        .clk(clk), .reset(reset),
        .inst_req(rr_inst_r.req), .inst_wr(rr_inst_r.wr), .inst_size(rr_inst_r.size),
        .inst_addr(rr_inst_r.addr), .inst_wdata(rr_inst_r.wdata),
        .inst_addr_ok(rr_inst_addr_ok), .inst_data_ok(rr_inst_data_ok), .inst_rdata(rr_inst_rdata),
        .data_req(rr_data_r.req), .data_wr(rr_data_r.wr), .data_size(rr_data_r.size),
        .data_addr(rr_data_r.addr), .data_wdata(rr_data_r.wdata),
        .data_addr_ok(rr_data_addr_ok), .data_data_ok(rr_data_data_ok), .data_rdata(rr_data_rdata),
        .mem_en(rr_mem_en), .mem_wen(rr_mem_wen), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata)
    );

    // Byte-lane SRAM with one cycle of read latency.
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wen[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
            mem_rdata <= sram[mem_addr[9:2]];
        end
    end

    always @(posedge clk) rr_mem_rdata <= rr_mem_en ? (rr_mem_addr ^ 32'hA5A5_0000) : 32'h0;

    function automatic req_t rd(input logic [31:0] a);
        req_t r;
        r = '0;
        r.req = 1'b1; r.size = 2'd2; r.addr = a;
        return r;
    endfunction

    function automatic req_t wr(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.req = 1'b1; r.wr = 1'b1; r.size = s; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input req_t i0, input req_t d0, input req_t i1, input req_t d1,
                                 input logic rst);
        @(negedge clk);
        r_inst = i0; r_data = d0; rr_inst_r = i1; rr_data_r = d1; reset = rst;
        #1;
    endtask

    task automatic checkOutput(input string name, input int which, input logic exp_iok,
                               input logic exp_dok, input logic [3:0] exp_wen,
                               input logic [31:0] exp_maddr, input logic [31:0] exp_rd,
                               input bit push);
        logic iok, dok, en;
        logic [3:0] wen;
        logic [31:0] maddr, mwd;
        req_t g;
        exp_t e;
        if (which == 0) begin
            iok = inst_addr_ok; dok = data_addr_ok; en = mem_en;
            wen = mem_wen; maddr = mem_addr; mwd = mem_wdata;
            g = exp_iok ? r_inst : r_data;
        end else begin
            iok = rr_inst_addr_ok; dok = rr_data_addr_ok; en = rr_mem_en;
            wen = rr_mem_wen; maddr = rr_mem_addr; mwd = rr_mem_wdata;
            g = exp_iok ? rr_inst_r : rr_data_r;
        end
        check({name, " inst_addr_ok"}, 32'(iok), 32'(exp_iok));
        check({name, " data_addr_ok"}, 32'(dok), 32'(exp_dok));
        if (exp_iok || exp_dok) begin
            check({name, " mem_en"}, 32'(en), 32'd1);
            check({name, " mem_wen"}, 32'(wen), 32'(exp_wen));
            check({name, " mem_addr"}, maddr, exp_maddr);
            check({name, " mem_wdata"}, mwd, g.wdata);
            if (push) begin
                e.due = cyc + 1; e.port = exp_dok; e.rdata = exp_rd;
                if (which == 0) q0.push_back(e); else q1.push_back(e);
            end
        end else begin
            check({name, " idle mem_en"}, 32'(en), 32'd0);
            check({name, " idle mem_wen"}, 32'(wen), 32'd0);
            check({name, " idle mem_addr"}, maddr, 32'h0);
            check({name, " idle mem_wdata"}, mwd, 32'h0);
        end
    endtask

    task automatic checkResponse(input string name, input bit have, input exp_t e,
                                 input logic iok, input logic dok,
                                 input logic [31:0] ird, input logic [31:0] drd);
        if (have) begin
            check({name, " inst_data_ok"}, 32'(iok), 32'(!e.port));
            check({name, " data_data_ok"}, 32'(dok), 32'(e.port));
            check({name, " inst_rdata"}, ird, e.port ? 32'h0 : e.rdata);
            check({name, " data_rdata"}, drd, e.port ? e.rdata : 32'h0);
        end else begin
            check({name, " quiet inst_data_ok"}, 32'(iok), 32'd0);
            check({name, " quiet data_data_ok"}, 32'(dok), 32'd0);
            check({name, " quiet inst_rdata"}, ird, 32'h0);
            check({name, " quiet data_rdata"}, drd, 32'h0);
        end
    endtask

    // Monitor: pops the response due this cycle (if any) for each instance.
    initial begin
        exp_t e0, e1;
        bit h0, h1;
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                h0 = 1'b0; h1 = 1'b0;
                while (q0.size() > 0 && q0[0].due < cyc) begin
                    tests++; fails++;
                    $display("[TB] FAIL dut0 response missed: due cycle %0d, now %0d", q0[0].due, cyc);
                    void'(q0.pop_front());
                end
                while (q1.size() > 0 && q1[0].due < cyc) begin
                    tests++; fails++;
                    $display("[TB] FAIL dut_rr response missed: due cycle %0d, now %0d", q1[0].due, cyc);
                    void'(q1.pop_front());
                end
                if (q0.size() > 0 && q0[0].due == cyc) begin e0 = q0.pop_front(); h0 = 1'b1; end
                if (q1.size() > 0 && q1[0].due == cyc) begin e1 = q1.pop_front(); h1 = 1'b1; end
                checkResponse("dut0 resp", h0, e0, inst_data_ok, data_data_ok, inst_rdata, data_rdata);
                checkResponse("dut_rr resp", h1, e1, rr_inst_data_ok, rr_data_data_ok,
                              rr_inst_rdata, rr_data_rdata);
            end
        end
    end

    initial begin
        bit exp_d;
        repeat (2) @(posedge clk);
        mon_on = 1'b1;
        applyStimulus(IDLE, IDLE, IDLE, IDLE, 1'b1);
        checkOutput("reset req-less", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

        // Round-robin collision straight out of reset: data first, then alternate.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(IDLE, IDLE, rd(32'h100), rd(32'h200), 1'b0);
            exp_d = (k % 2 == 0);
            checkOutput($sformatf("rr collision %0d", k), 1, !exp_d, exp_d, 4'h0,
                        exp_d ? 32'h200 : 32'h100, exp_d ? 32'hA5A5_0200 : 32'hA5A5_0100, 1);
            checkOutput($sformatf("rr collision %0d dut0 idle", k), 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        end

        applyStimulus(IDLE, wr(2'd2, 32'h10, 32'h1122_3344), IDLE, IDLE, 1'b0);
        checkOutput("word write 0x10", 0, 0, 1, 4'hF, 32'h10, 32'h0, 1);
        applyStimulus(IDLE, wr(2'd2, 32'hBFC0_0004, 32'h2408_0001), IDLE, IDLE, 1'b0);
        checkOutput("word write boot", 0, 0, 1, 4'hF, 32'hBFC0_0004, 32'h0, 1);
        applyStimulus(rd(32'hBFC0_0004), IDLE, IDLE, IDLE, 1'b0);
        checkOutput("inst read boot", 0, 1, 0, 4'h0, 32'hBFC0_0004, 32'h2408_0001, 1);
        applyStimulus(IDLE, wr(2'd0, 32'h13, 32'hAB00_0000), IDLE, IDLE, 1'b0);
        checkOutput("byte write a=3", 0, 0, 1, 4'h8, 32'h10, 32'h0, 1);
        applyStimulus(IDLE, wr(2'd1, 32'h12, 32'hCDEF_0000), IDLE, IDLE, 1'b0);
        checkOutput("half write a=2", 0, 0, 1, 4'hC, 32'h10, 32'h0, 1);
        applyStimulus(IDLE, wr(2'd1, 32'h11, 32'hFFFF_FFFF), IDLE, IDLE, 1'b0);
        checkOutput("half write a=1 misaligned", 0, 0, 1, 4'h0, 32'h10, 32'h0, 1);
        applyStimulus(IDLE, wr(2'd0, 32'h11, 32'h0000_9900), IDLE, IDLE, 1'b0);
        checkOutput("byte write a=1", 0, 0, 1, 4'h2, 32'h10, 32'h0, 1);
        applyStimulus(IDLE, wr(2'd3, 32'h22, 32'h5566_7788), IDLE, IDLE, 1'b0);
        checkOutput("size3 write a=2", 0, 0, 1, 4'hF, 32'h20, 32'h0, 1);

        // Back-to-back reads on different ports.
        applyStimulus(rd(32'hBFC0_0004), IDLE, IDLE, IDLE, 1'b0);
        checkOutput("b2b inst read", 0, 1, 0, 4'h0, 32'hBFC0_0004, 32'h2408_0001, 1);
        applyStimulus(IDLE, rd(32'h10), IDLE, IDLE, 1'b0);
        checkOutput("b2b data read 0x10", 0, 0, 1, 4'h0, 32'h10, 32'hCDEF_9944, 1);
        applyStimulus(IDLE, rd(32'h22), IDLE, IDLE, 1'b0);
        checkOutput("data read 0x20", 0, 0, 1, 4'h0, 32'h20, 32'h5566_7788, 1);
        applyStimulus(IDLE, IDLE, IDLE, IDLE, 1'b0);
        checkOutput("idle dut0", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);

        // Fixed priority with starvation guard: D D D D I D D D D I.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(rd(32'hBFC0_0004), rd(32'h20), IDLE, IDLE, 1'b0);
            exp_d = !(k == 4 || k == 9);
            checkOutput($sformatf("fixed collision %0d", k), 0, !exp_d, exp_d, 4'h0,
                        exp_d ? 32'h20 : 32'hBFC0_0004, exp_d ? 32'h5566_7788 : 32'h2408_0001, 1);
        end
        applyStimulus(IDLE, IDLE, IDLE, IDLE, 1'b0);

        // Reset while a read is outstanding drops its response.
        applyStimulus(rd(32'hBFC0_0004), IDLE, rd(32'h100), IDLE, 1'b0);
        checkOutput("pre-reset read dut0", 0, 1, 0, 4'h0, 32'hBFC0_0004, 32'h0, 0);
        checkOutput("pre-reset read rr", 1, 1, 0, 4'h0, 32'h100, 32'h0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(rd(32'hBFC0_0004), rd(32'h20), rd(32'h100), rd(32'h200), 1'b1);
            checkOutput($sformatf("reset ignores req dut0 %0d", k), 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
            checkOutput($sformatf("reset ignores req rr %0d", k), 1, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        end
        applyStimulus(IDLE, IDLE, IDLE, IDLE, 1'b0);
        checkOutput("post-reset idle dut0", 0, 0, 0, 4'h0, 32'h0, 32'h0, 0);
        applyStimulus(rd(32'hBFC0_0004), rd(32'h20), rd(32'h100), rd(32'h200), 1'b0);
        checkOutput("post-reset collision dut0", 0, 0, 1, 4'h0, 32'h20, 32'h5566_7788, 1);
        checkOutput("post-reset collision rr", 1, 0, 1, 4'h0, 32'h200, 32'hA5A5_0200, 1);
        applyStimulus(rd(32'hBFC0_0004), rd(32'h20), rd(32'h100), rd(32'h200), 1'b0);
        checkOutput("post-reset collision 2 dut0", 0, 0, 1, 4'h0, 32'h20, 32'h5566_7788, 1);
        checkOutput("post-reset collision 2 rr", 1, 1, 0, 4'h0, 32'h100, 32'hA5A5_0100, 1);
        applyStimulus(IDLE, IDLE, IDLE, IDLE, 1'b0);

        repeat (3) @(negedge clk);
        #3;
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d/%0d responses outstanding, expected 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vie_sram_arbiter.md
Name: vie_sram_arbiter

Overview:
- Memory-side block directly downstream of the CPU core.
- Takes the core's two SRAM-like request ports (instruction and data) and serves them from one shared single-port synchronous SRAM with a fixed 1-cycle read latency.
- Provides:
  - request arbitration with a starvation guard;
  - byte-lane write-enable generation;
  - return of each response (data_ok/rdata) to the port that issued the request.

Parameters:
- ARB_MODE, 0: 0 = fixed priority (data over inst); 1 = round-robin on collision.
- STARVE_LIMIT, 4: in fixed mode, consecutive lost cycles after which inst wins the next collision; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  inst request valid.
- inst_wr  in  1  1 = write.
- inst_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- inst_addr  in  32  byte address.
- inst_wdata  in  32  write data, lane-aligned by the core.
- inst_addr_ok  out  1  request accepted this cycle.
- inst_data_ok  out  1  response valid.
- inst_rdata  out  32  read data, raw word.
- data_req, data_wr, data_size, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: same as the inst_* ports, for the data port.
- mem_en  out  1  SRAM access enable.
- mem_wen  out  4  SRAM byte write enables.
- mem_addr  out  32  word address {addr[31:2], 2'b00}.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en.

Behaviour:
- Acceptance:
  - At most one request accepted per cycle.
  - addr_ok is combinational from req and the arbitration state.
  - addr_ok is 0 while reset is high.
  - Accepted in cycle T means mem_en = 1 in T, carrying the selected port's address, wen and wdata.
  - When nothing is accepted: mem_en = 0, mem_wen = 0, mem_addr = 0, mem_wdata = 0.
- Response:
  - A 1-deep response register records {valid, port, wr}.
  - In T+1, the recorded port's data_ok = 1 for exactly one cycle, for both reads and writes.
  - rdata = mem_rdata in T+1 for reads; rdata = 0 otherwise.
  - The other port's data_ok = 0.
  - No back-pressure on data_ok; a new request may be accepted in T+1 while the T response is returned, giving full throughput.
- Arbitration:
  - Only one port requesting: it is granted.
  - ARB_MODE = 0 collision: data wins, unless starve_cnt == STARVE_LIMIT, in which case inst wins.
  - starve_cnt (4-bit):
    - increments on each cycle inst_req = 1 and inst is not granted, saturating at STARVE_LIMIT;
    - clears when inst is granted or inst_req = 0.
  - ARB_MODE = 1 collision: the port not granted last time wins. last_grant is a register updated on every grant; reset value = inst, so data wins the first collision.
- Write enables (wr = 1), with a = addr[1:0]:
  - byte: wen = 4'b0001 << a.
  - half: a = 0 gives 4'b0011; a = 2 gives 4'b1100; a odd (misaligned) gives wen = 0, with the request still accepted and data_ok still returned.
  - word or size 3: wen = 4'b1111, regardless of a.
- Reads: wen = 0; the full word is returned; the core performs extraction.
- Reset:
  - Clears the response register, starve_cnt and last_grant.
  - In the first cycle after reset deasserts, both data_ok = 0 and both rdata = 0.
  - Reset asserted in T+1 of an outstanding access suppresses that data_ok; the response is dropped.
- Both req inputs are ignored in any cycle where reset = 1.

Test Plan:
- Single inst read: inst_req = 1, addr 0xBFC0_0004, SRAM word 0x2408_0001 → inst_addr_ok in T, mem_addr = 0xBFC0_0004, mem_wen = 0; inst_data_ok = 1 in T+1 with inst_rdata = 0x2408_0001; data_data_ok stays 0.
- Byte and half writes: data write byte addr 0x...03 → mem_wen = 4'b1000. Half write addr 0x...02 → 4'b1100. Half write addr 0x...01 → mem_wen = 0, with data_addr_ok and data_data_ok both still 1.
- Fixed-priority collision, ARB_MODE = 0, STARVE_LIMIT = 4, both req held high:
  - grants are data × 4, then inst, then data × 4, and so on;
  - starve_cnt reaches 4 before each inst grant;
  - each data_ok is routed to the matching port one cycle after its addr_ok.
- Round-robin collision, ARB_MODE = 1, both req held high: grants alternate data, inst, data, inst from the first cycle after reset; one access per cycle; no idle cycles.
- Back-to-back reads: inst read A in T, data read B in T+1 → inst_data_ok with A's word in T+1 and data_data_ok with B's word in T+2, with no overlap on the same port.
- Reset mid-operation: read accepted in T, reset = 1 in T+1 → no data_ok in T+1 or T+2. After release, the first new request is served normally, and a collision grants data first (last_grant reset to inst).
